// File: rtl/accum_table_pkg.sv
// Shared definitions for the accumulator table controllers.
// Holds the default geometry, the controller FSM encoding and the
// row-address helper shared by the write and read sequencers.
package accum_table_pkg;

  localparam int DEF_MAX_OUT_ROWS   = 128;
  localparam int DEF_MAX_OUT_COLS   = 128;
  localparam int DEF_SYS_ARR_ROWS   = 16;
  localparam int DEF_SYS_ARR_COLS   = 16;
  localparam int DEF_NUM_SUBMATS_M  = DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS;
  localparam int DEF_NUM_SUBMATS_N  = DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS;
  localparam int DEF_NUM_ACCUM_ROWS = DEF_MAX_OUT_ROWS * DEF_NUM_SUBMATS_N;
  localparam int DEF_ADDR_WIDTH     = $clog2(DEF_NUM_ACCUM_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ROWS  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Table row for (submat_m, submat_n, sub_row). Each column block of the
  // output owns max_out_rows consecutive table rows.
  function automatic int unsigned accum_addr(
    input int unsigned submat_m,
    input int unsigned submat_n,
    input int unsigned sub_row,
    input int unsigned max_out_rows,
    input int unsigned sys_arr_rows
  );
    return submat_n * max_out_rows + submat_m * sys_arr_rows + sub_row;
  endfunction

endpackage

// File: rtl/accum_table_wr_seq_col_skew_pipe.sv
// Column skew shift register: stage c+1 takes stage c every cycle, so each
// column sees the column-0 stream delayed by its column index.
module col_skew_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH*DEPTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the column stream one stage per cycle; reset empties every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // Flatten stages onto the output bus, stage 0 in the LSBs.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) dout[i*WIDTH +: WIDTH] = stage[i];
  end

endmodule

// File: rtl/accum_table_wr_seq.sv
// Accumulator table write sequencer. One start launches a full sub-matrix
// write-back: optional latency wait, R column-0 row writes, then a drain
// while the skew pipe carries the tail out to the last column.
//
// Handshake: start is sampled on a rising edge and is taken only while the
// FSM is idle (busy low); busy rises the cycle after acceptance and stays
// high through the done cycle; done pulses for one cycle together with the
// last column's last write. Anything on start while busy is dropped.
module accum_table_wr_seq
  import accum_table_pkg::*;
#(
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
  parameter int PIPE_DELAY   = 0,
  localparam int NUM_SUBMATS_M  = MAX_OUT_ROWS / SYS_ARR_ROWS,
  localparam int NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * NUM_SUBMATS_N,
  localparam int ADDR_WIDTH     = $clog2(NUM_ACCUM_ROWS),
  localparam int SM_W = (NUM_SUBMATS_M > 1) ? $clog2(NUM_SUBMATS_M) : 1,
  localparam int SN_W = (NUM_SUBMATS_N > 1) ? $clog2(NUM_SUBMATS_N) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         accum_mode,
  input  logic [SM_W-1:0]              submat_m,
  input  logic [SN_W-1:0]              submat_n,
  output logic                         busy,
  output logic                         done,
  output logic [SYS_ARR_COLS-1:0]      wr_en_out,
  output logic [SYS_ARR_COLS-1:0]      wr_accum_out,
  output logic [ADDR_WIDTH*SYS_ARR_COLS-1:0] wr_addr_out,
  output logic [1:0]                   state_dbg
);

  localparam int PW = ADDR_WIDTH + 2;
  localparam logic [15:0] WAIT_LAST  = 16'(PIPE_DELAY - 1);
  localparam logic [15:0] ROW_LAST   = 16'(SYS_ARR_ROWS - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(SYS_ARR_COLS - 2);

  state_t            state, state_d;
  logic [15:0]       cnt, cnt_d;
  logic              mode_q;
  logic [SM_W-1:0]   m_q;
  logic [SN_W-1:0]   n_q;
  logic              mode_eff;
  logic [SM_W-1:0]   m_eff;
  logic [SN_W-1:0]   n_eff;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [PW-1:0]     stage0;
  logic [PW*SYS_ARR_COLS-1:0] pipe_out;

  assign state_dbg = state;

  // Next state and phase counter; cnt is the row index while in ROWS.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = (PIPE_DELAY > 0) ? ST_WAIT : ST_ROWS;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_d = ST_ROWS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      ST_ROWS: begin
        if (cnt == ROW_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Column-0 stage is built from the next state so the registered write
  // lands in the same cycle the FSM occupies the matching ROWS slot; in
  // the acceptance cycle the live inputs stand in for the latched copies.
  always_comb begin
    mode_eff = (state == ST_IDLE) ? accum_mode : mode_q;
    m_eff    = (state == ST_IDLE) ? submat_m   : m_q;
    n_eff    = (state == ST_IDLE) ? submat_n   : n_q;
    row_addr = ADDR_WIDTH'(accum_addr(32'(m_eff), 32'(n_eff), 32'(cnt_d),
                                      MAX_OUT_ROWS, SYS_ARR_ROWS));
    stage0   = '0;
    if (state_d == ST_ROWS) stage0 = {1'b1, mode_eff, row_addr};
  end

  // FSM, counter, handshake flags and latched launch parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= 1'b0;
      m_q    <= '0;
      n_q    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      busy  <= (state_d != ST_IDLE);
      done  <= (state_d == ST_DRAIN) && (cnt_d == DRAIN_LAST);
      if (state == ST_IDLE && start) begin
        mode_q <= accum_mode;
        m_q    <= submat_m;
        n_q    <= submat_n;
      end
    end
  end

  col_skew_pipe #(
    .WIDTH (PW),
    .DEPTH (SYS_ARR_COLS)
  ) u_skew (
    .clk   (clk),
    .reset (reset),
    .din   (stage0),
    .dout  (pipe_out)
  );

  // Unpack the skew pipe per column, forcing flag and address to zero
  // wherever the column is not writing.
  always_comb begin
    wr_en_out    = '0;
    wr_accum_out = '0;
    wr_addr_out  = '0;
    for (int c = 0; c < SYS_ARR_COLS; c++) begin
      wr_en_out[c] = pipe_out[c*PW + PW - 1];
      if (pipe_out[c*PW + PW - 1]) begin
        wr_accum_out[c] = pipe_out[c*PW + PW - 2];
        wr_addr_out[c*ADDR_WIDTH +: ADDR_WIDTH] = pipe_out[c*PW +: ADDR_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_accum_table_wr_seq.sv
// Bench for accum_table_wr_seq: a PIPE_DELAY=2 instance checked against a
// per-column expected-write scoreboard, plus a PIPE_DELAY=0 instance
// checked at fixed cycles.
module tb_accum_table_wr_seq;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int MOR = 16;
  localparam int MOC = 16;
  localparam int PD  = 2;
  localparam int AW  = 6;
  localparam int EW  = 32 + 1 + AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (PIPE_DELAY = 2) ----------------
  logic          start = 1'b0;
  logic          accum_mode = 1'b0;
  logic [1:0]    submat_m = '0;
  logic [1:0]    submat_n = '0;
  logic          busy, done;
  logic [C-1:0]  wr_en_out, wr_accum_out;
  logic [AW*C-1:0] wr_addr_out;
  logic [1:0]    state_dbg;

  accum_table_wr_seq #(
    .MAX_OUT_ROWS (MOR), .MAX_OUT_COLS (MOC),
    .SYS_ARR_ROWS (R),   .SYS_ARR_COLS (C),
    .PIPE_DELAY   (PD)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .accum_mode (accum_mode),
    .submat_m (submat_m), .submat_n (submat_n), .busy (busy), .done (done),
    .wr_en_out (wr_en_out), .wr_accum_out (wr_accum_out),
    .wr_addr_out (wr_addr_out), .state_dbg (state_dbg)
  );

  // ---------------- DUT (PIPE_DELAY = 0) ----------------
  logic          start_z = 1'b0;
  logic          accum_mode_z = 1'b0;
  logic [1:0]    submat_m_z = '0;
  logic [1:0]    submat_n_z = '0;
  logic          busy_z, done_z;
  logic [C-1:0]  wr_en_out_z, wr_accum_out_z;
  logic [AW*C-1:0] wr_addr_out_z;
  logic [1:0]    state_dbg_z;

  accum_table_wr_seq #(
    .MAX_OUT_ROWS (MOR), .MAX_OUT_COLS (MOC),
    .SYS_ARR_ROWS (R),   .SYS_ARR_COLS (C),
    .PIPE_DELAY   (0)
  ) dut_z (
    .clk (clk), .reset (reset), .start (start_z), .accum_mode (accum_mode_z),
    .submat_m (submat_m_z), .submat_n (submat_n_z), .busy (busy_z),
    .done (done_z), .wr_en_out (wr_en_out_z), .wr_accum_out (wr_accum_out_z),
    .wr_addr_out (wr_addr_out_z), .state_dbg (state_dbg_z)
  );

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  // Entry: {cycle, accum, addr}
  logic [EW-1:0] exp_q [C][$];
  int exp_done_q[$];
  int busy_lo   = 0;
  int busy_hi   = -1;
  int next_free = 0;
  bit mon_on    = 1'b0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; if the model says the block is idle, queue
  // every column write it must produce and the done cycle.
  task automatic launch(input int m, input int n, input bit mode);
    int t;
    t = cyc;
    submat_m   = 2'(m);
    submat_n   = 2'(n);
    accum_mode = mode;
    start      = 1'b1;
    if (t >= next_free) begin
      for (int c = 0; c < C; c++)
        for (int r = 0; r < R; r++)
          exp_q[c].push_back({32'(t + 1 + PD + c + r), mode,
                              AW'(n * MOR + m * R + r)});
      exp_done_q.push_back(t + PD + R + C - 1);
      busy_lo   = t + 1;
      busy_hi   = t + PD + R + C - 1;
      next_free = t + PD + R + C;
    end
    next_cycle();
    start = 1'b0;
  endtask

  // One-cycle reset: whatever was in flight is abandoned.
  task automatic pulse_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < C; c++) exp_q[c].delete();
    exp_done_q.delete();
    busy_hi   = -1;
    next_free = cyc;
  endtask

  // Monitor: mid-cycle compare of every column, busy and done.
  always @(negedge clk) begin
    logic [EW-1:0] got, e;
    if (mon_on) begin
      for (int c = 0; c < C; c++) begin
        got = {32'(cyc), wr_accum_out[c], wr_addr_out[c*AW +: AW]};
        if (wr_en_out[c] ||
            (exp_q[c].size() > 0 && exp_q[c][0][EW-1:AW+1] == 32'(cyc))) begin
          if (exp_q[c].size() == 0) begin
            check($sformatf("wr_unexp_c%0d", c), 64'(wr_en_out[c]), 64'd0);
          end else begin
            e = exp_q[c].pop_front();
            check($sformatf("wr_c%0d", c), {wr_en_out[c], got}, {1'b1, e});
          end
        end else begin
          check($sformatf("gate_c%0d", c),
                {wr_accum_out[c], wr_addr_out[c*AW +: AW]}, 64'd0);
        end
      end
      check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      if (done || (exp_done_q.size() > 0 && exp_done_q[0] == cyc)) begin
        if (exp_done_q.size() == 0) check("done_unexp", 64'(done), 64'd0);
        else check("done_cyc", {done, 32'(cyc)}, {1'b1, 32'(exp_done_q.pop_front())});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    // start held together with reset must be ignored
    reset = 1'b1;
    start = 1'b1;
    repeat (3) next_cycle();
    reset = 1'b0;
    start = 1'b0;
    next_free = cyc;
    mon_on = 1'b1;
    next_cycle();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(wr_en_out), 64'd0);

    // idle after reset
    repeat (20) next_cycle();
    check("idle_en", 64'(wr_en_out), 64'd0);
    check("idle_accum", 64'(wr_accum_out), 64'd0);
    check("idle_addr", 64'(wr_addr_out), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy_z", 64'(busy_z), 64'd0);

    // nominal then back-to-back launch at T+10, stray start during busy
    launch(1, 2, 1'b0);
    repeat (9) next_cycle();
    launch(3, 3, 1'b1);
    repeat (4) next_cycle();
    launch(0, 1, 1'b1);
    repeat (10) next_cycle();
    check("b2b_idle", 64'(busy), 64'd0);

    // reset mid-ROWS, then a fresh launch
    launch(2, 1, 1'b1);
    repeat (4) next_cycle();
    pulse_reset();
    check("mid_rst_en", 64'(wr_en_out), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    repeat (2) next_cycle();
    launch(1, 1, 1'b0);
    repeat (12) next_cycle();

    // random launches, some landing while busy
    repeat (8) begin
      launch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      repeat ($urandom_range(6, 12)) next_cycle();
    end
    repeat (12) next_cycle();

    // PIPE_DELAY=0 instance
    t = cyc;
    submat_m_z   = 2'd2;
    submat_n_z   = 2'd1;
    accum_mode_z = 1'b1;
    start_z      = 1'b1;
    next_cycle();
    start_z = 1'b0;
    check("z_en0_first", 64'(wr_en_out_z[0]), 64'd1);
    check("z_addr0_first", 64'(wr_addr_out_z[AW-1:0]), 64'd24);
    check("z_accum0", 64'(wr_accum_out_z[0]), 64'd1);
    check("z_busy", 64'(busy_z), 64'd1);
    repeat (5) next_cycle();
    check("z_done_early", {64'(done_z)}, 64'd0);
    next_cycle();
    check("z_done_cyc", 64'(cyc - t), 64'd7);
    check("z_done", 64'(done_z), 64'd1);
    check("z_en3_last", 64'(wr_en_out_z[3]), 64'd1);
    check("z_addr3_last", 64'(wr_addr_out_z[3*AW +: AW]), 64'd27);
    next_cycle();
    check("z_busy_low", 64'(busy_z), 64'd0);
    check("z_en_low", 64'(wr_en_out_z), 64'd0);

    repeat (10) next_cycle();
    for (int c = 0; c < C; c++)
      check($sformatf("leftover_c%0d", c), 64'(exp_q[c].size()), 64'd0);
    check("leftover_done", 64'(exp_done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // time bound on the whole run
  initial begin
    #100000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

endmodule
